// File: rtl/encoder_pkg.sv
// Shared sizes, state encoding and pointer reset value for the 8-to-3 request encoder.
package encoder_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  localparam logic [IDX_W-1:0] PTR_RESET = 3'd7;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

endpackage

// File: rtl/prio_pick8.sv
// Combinational picker: highest set index, or first set index after start (mod 8).
module prio_pick8
  import encoder_pkg::*;
(
  input  logic [N_REQ-1:0] pend,
  input  logic [IDX_W-1:0] start,
  input  logic             rr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] j;

  always_comb begin
    idx = '0;
    j   = '0;
    any = |pend;
    if (rr) begin
      // walk from the farthest candidate back so the nearest one after start wins
      for (int k = N_REQ; k >= 1; k--) begin
        j = start + IDX_W'(k);
        if (pend[j]) idx = j;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (pend[i]) idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/encoder8x3_irq.sv
// Registered 8-to-3 request encoder: edge capture into pend, one index presented per valid/ready handshake.
//   state   | meaning
//   IDLE    | nothing presented; V=0, selects from pend when non-empty
//   PRESENT | Y valid and frozen until R accepts it
module encoder8x3_irq
  import encoder_pkg::*;
#(
  parameter bit RR = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] D,
  input  logic             E,
  input  logic             R,
  input  logic             clr,
  output logic [IDX_W-1:0] Y,
  output logic             V,
  output logic [N_REQ-1:0] pend,
  output logic             ovf
);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] y_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [N_REQ-1:0] d_q;
  logic [N_REQ-1:0] rise;
  logic [N_REQ-1:0] served;
  logic             ovf_set;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  assign V       = (state == PRESENT);
  assign rise    = D & ~d_q & {N_REQ{E}};
  assign served  = (V && R) ? (N_REQ'(1) << Y) : '0;
  // a re-raise on the line being served this cycle is a fresh request, not an overflow
  assign ovf_set = |(rise & pend & ~served);

  prio_pick8 u_pick (
    .pend  (pend),
    .start (ptr),
    .rr    (RR),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q  <= '0;
      pend <= '0;
      ovf  <= 1'b0;
    end else begin
      d_q  <= D;
      pend <= (pend & ~served) | rise;
      if (ovf_set)  ovf <= 1'b1;
      else if (clr) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      Y     <= '0;
      ptr   <= PTR_RESET;
    end else begin
      state <= state_nxt;
      Y     <= y_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    y_nxt     = Y;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (pick_any) begin
          y_nxt     = pick_idx;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (R) begin
          ptr_nxt   = Y;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_encoder8x3_irq.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-level reference model,
// run on a fixed-priority and a round-robin instance side by side.
module tb_encoder8x3_irq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] D = 8'h00;
  logic       E = 1'b1;
  logic       R = 1'b0;
  logic       clr = 1'b0;

  logic [2:0] y0, y1;
  logic       v0, v1;
  logic [7:0] pend0, pend1;
  logic       ovf0, ovf1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  encoder8x3_irq #(.RR(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .D(D), .E(E), .R(R), .clr(clr),
    .Y(y0), .V(v0), .pend(pend0), .ovf(ovf0)
  );

  encoder8x3_irq #(.RR(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .D(D), .E(E), .R(R), .clr(clr),
    .Y(y1), .V(v1), .pend(pend1), .ovf(ovf1)
  );

  // Reference model: index 0 = fixed priority, 1 = round robin
  logic [7:0] m_dq;
  logic [7:0] m_pend [2];
  logic       m_ovf  [2];
  logic       m_v    [2];
  int         m_y    [2];
  int         m_ptr  [2];

  function automatic int ref_pick(input logic [7:0] p, input int ptr, input int mode);
    int r;
    r = 0;
    if (mode == 0) begin
      for (int i = 7; i >= 0; i--)
        if (p[i]) return i;
    end else begin
      for (int k = 1; k <= 8; k++) begin
        r = (ptr + k) % 8;
        if (p[r]) return r;
      end
    end
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [7:0] rise;
    logic [7:0] p_old;
    logic       hs;
    if (!rst_n) begin
      m_dq = 8'h00;
      for (int m = 0; m < 2; m++) begin
        m_pend[m] = 8'h00; m_ovf[m] = 1'b0; m_v[m] = 1'b0; m_y[m] = 0; m_ptr[m] = 7;
      end
    end else begin
      rise = E ? (D & ~m_dq) : 8'h00;
      m_dq = D;
      for (int m = 0; m < 2; m++) begin
        p_old = m_pend[m];
        hs = m_v[m] && R;
        for (int i = 0; i < 8; i++) begin
          if (hs && i == m_y[m]) m_pend[m][i] = rise[i];
          else if (rise[i]) m_pend[m][i] = 1'b1;
          if (rise[i] && p_old[i] && !(hs && i == m_y[m])) m_ovf[m] = 1'b1;
          else if (clr && !(rise[i] && p_old[i] && !(hs && i == m_y[m])) && i == 7 &&
                   !(|(rise & p_old & ~(hs ? (8'h01 << m_y[m]) : 8'h00)))) m_ovf[m] = 1'b0;
        end
        if (m_v[m]) begin
          if (R) begin m_v[m] = 1'b0; m_ptr[m] = m_y[m]; end
        end else if (p_old != 8'h00) begin
          m_y[m] = ref_pick(p_old, m_ptr[m], m);
          m_v[m] = 1'b1;
        end
      end
    end
  end

  task automatic reset_all();
    D = 8'h00; R = 1'b0; clr = 1'b0; E = 1'b1;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (v0 !== 1'b0 || y0 !== 3'd0) begin errors++; $display("FAIL reset_vy0 got V=%b Y=%0d exp V=0 Y=0", v0, y0); end
    checks++; if (pend0 !== 8'h00 || ovf0 !== 1'b0) begin errors++; $display("FAIL reset_po0 got pend=%h ovf=%b exp 00/0", pend0, ovf0); end
    checks++; if (v1 !== 1'b0 || pend1 !== 8'h00 || ovf1 !== 1'b0) begin errors++; $display("FAIL reset_dut1 got V=%b pend=%h ovf=%b exp 0/00/0", v1, pend1, ovf1); end
    rst_n = 1'b1;
  endtask

  task automatic test_fixed_priority();
    reset_all();
    E = 1'b1; R = 1'b1; D = 8'h24;
    @(negedge clk); D = 8'h00;
    checks++; if (pend0 !== 8'h24 || v0 !== 1'b0) begin errors++; $display("FAIL fp_capture got pend=%h V=%b exp 24/0", pend0, v0); end
    @(negedge clk);
    checks++; if (v0 !== 1'b1 || y0 !== 3'd5) begin errors++; $display("FAIL fp_first got V=%b Y=%0d exp 1/5", v0, y0); end
    @(negedge clk);
    checks++; if (v0 !== 1'b0 || pend0 !== 8'h04) begin errors++; $display("FAIL fp_gap got V=%b pend=%h exp 0/04", v0, pend0); end
    @(negedge clk);
    checks++; if (v0 !== 1'b1 || y0 !== 3'd2) begin errors++; $display("FAIL fp_second got V=%b Y=%0d exp 1/2", v0, y0); end
    @(negedge clk);
    checks++; if (v0 !== 1'b0 || pend0 !== 8'h00) begin errors++; $display("FAIL fp_done got V=%b pend=%h exp 0/00", v0, pend0); end
  endtask

  task automatic test_round_robin();
    reset_all();
    R = 1'b1; D = 8'h81;
    @(negedge clk); D = 8'h00;
    @(negedge clk);
    checks++; if (v1 !== 1'b1 || y1 !== 3'd0) begin errors++; $display("FAIL rr_first got V=%b Y=%0d exp 1/0", v1, y1); end
    checks++; if (v0 !== 1'b1 || y0 !== 3'd7) begin errors++; $display("FAIL rr_fixed_first got V=%b Y=%0d exp 1/7", v0, y0); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (v1 !== 1'b1 || y1 !== 3'd7) begin errors++; $display("FAIL rr_second got V=%b Y=%0d exp 1/7", v1, y1); end
    @(negedge clk);
    checks++; if (pend1 !== 8'h00) begin errors++; $display("FAIL rr_drained got pend=%h exp 00", pend1); end
    D = 8'h81;
    @(negedge clk); D = 8'h00;
    @(negedge clk);
    checks++; if (v1 !== 1'b1 || y1 !== 3'd0) begin errors++; $display("FAIL rr_wrap got V=%b Y=%0d exp 1/0", v1, y1); end
    R = 1'b0;
  endtask

  task automatic test_backpressure();
    reset_all();
    R = 1'b0; D = 8'h08;
    @(negedge clk); D = 8'h00;
    @(negedge clk);
    D = 8'h40;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); D = 8'h00;
      checks++; if (v0 !== 1'b1 || y0 !== 3'd3) begin errors++; $display("FAIL bp_hold cyc %0d got V=%b Y=%0d exp 1/3", c, v0, y0); end
    end
    checks++; if (pend0 !== 8'h48) begin errors++; $display("FAIL bp_pend got %h exp 48", pend0); end
    R = 1'b1;
    @(negedge clk);
    checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL bp_release got V=%b exp 0", v0); end
    @(negedge clk);
    checks++; if (v0 !== 1'b1 || y0 !== 3'd6) begin errors++; $display("FAIL bp_next got V=%b Y=%0d exp 1/6", v0, y0); end
    R = 1'b0;
  endtask

  task automatic test_overflow();
    reset_all();
    R = 1'b0; D = 8'h02;
    @(negedge clk); D = 8'h00;
    @(negedge clk); D = 8'h02;
    @(negedge clk); D = 8'h00;
    checks++; if (ovf0 !== 1'b1 || pend0 !== 8'h02) begin errors++; $display("FAIL ovf_set got ovf=%b pend=%h exp 1/02", ovf0, pend0); end
    clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b exp 0", ovf0); end
    D = 8'h02; R = 1'b1;
    @(negedge clk); D = 8'h00; R = 1'b0;
    checks++; if (pend0 !== 8'h02 || ovf0 !== 1'b0 || v0 !== 1'b0) begin errors++; $display("FAIL ovf_serve got pend=%h ovf=%b V=%b exp 02/0/0", pend0, ovf0, v0); end
    @(negedge clk);
    D = 8'h02; clr = 1'b1;
    @(negedge clk); D = 8'h00; clr = 1'b0;
    checks++; if (ovf0 !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %b exp 1", ovf0); end
  endtask

  task automatic test_enable();
    reset_all();
    E = 1'b0; R = 1'b0;
    for (int c = 0; c < 6; c++) begin
      D = (c % 2 == 0) ? 8'hFF : 8'h00;
      @(negedge clk);
    end
    D = 8'hFF;
    @(negedge clk);
    checks++; if (pend0 !== 8'h00 || pend1 !== 8'h00) begin errors++; $display("FAIL en_off got pend0=%h pend1=%h exp 00", pend0, pend1); end
    E = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if (pend0 !== 8'h00) begin errors++; $display("FAIL en_level got pend=%h exp 00", pend0); end
    D = 8'h00;
    @(negedge clk); D = 8'hFF;
    @(negedge clk);
    checks++; if (pend0 !== 8'hFF) begin errors++; $display("FAIL en_rise got pend=%h exp FF", pend0); end
    D = 8'h00;
  endtask

  task automatic test_reset_mid();
    reset_all();
    R = 1'b0; D = 8'h81;
    @(negedge clk); D = 8'h00;
    @(negedge clk); D = 8'h81;
    @(negedge clk); D = 8'h01;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (v0 !== 1'b0 || y0 !== 3'd0 || pend0 !== 8'h00 || ovf0 !== 1'b0) begin errors++; $display("FAIL async_reset got V=%b Y=%0d pend=%h ovf=%b exp 0/0/00/0", v0, y0, pend0, ovf0); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if (pend0 !== 8'h01) begin errors++; $display("FAIL reset_held_d got pend=%h exp 01", pend0); end
    D = 8'h00;
  endtask

  task automatic test_random();
    reset_all();
    for (int c = 0; c < 600; c++) begin
      D   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : D & 8'($urandom);
      E   = ($urandom_range(0, 7) != 0);
      R   = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 5) == 0);
      @(negedge clk);
      checks++; if (v0 !== m_v[0] || (m_v[0] && y0 !== 3'(m_y[0])) || pend0 !== m_pend[0] || ovf0 !== m_ovf[0]) begin
        errors++; $display("FAIL rand_fixed cyc %0d got V=%b Y=%0d pend=%h ovf=%b exp V=%b Y=%0d pend=%h ovf=%b",
          c, v0, y0, pend0, ovf0, m_v[0], m_y[0], m_pend[0], m_ovf[0]);
      end
      checks++; if (v1 !== m_v[1] || (m_v[1] && y1 !== 3'(m_y[1])) || pend1 !== m_pend[1] || ovf1 !== m_ovf[1]) begin
        errors++; $display("FAIL rand_rr cyc %0d got V=%b Y=%0d pend=%h ovf=%b exp V=%b Y=%0d pend=%h ovf=%b",
          c, v1, y1, pend1, ovf1, m_v[1], m_y[1], m_pend[1], m_ovf[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_enable();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/encoder8x3_irq.md
# encoder8x3_irq

Registered 8-to-3 request encoder, the inverse of the team's 3-to-8 enable decoder. It captures rising edges on eight request lines into a pending register and presents the 3-bit index of one pending request at a time. A valid/ready handshake clears the served request. It sits between discrete request sources and a consumer that expects a binary index, and can feed a `decoder3x8_st` acknowledge path directly.

## Interface
- `RR`, default 0: selection mode. 0 = fixed priority, highest index wins. 1 = round-robin.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `D`  in  8  request lines; a 0→1 edge on `D[i]` raises request i.
- `E`  in  1  capture enable; when 0, new edges are ignored.
- `R`  in  1  consumer ready.
- `clr`  in  1  clears the sticky overflow flag.
- `Y`  out  3  encoded index of the presented request.
- `V`  out  1  `Y` is valid.
- `pend`  out  8  pending-request register.
- `ovf`  out  1  sticky flag: an edge arrived on an already-pending line.

Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.

## Operation
- **Edge detect.** `d_q <= D` every cycle, regardless of `E`. `rise = D & ~d_q`, gated by `E`.
- **Pending update.** Each edge: `pend <= (pend & ~served) | rise`.
  - `served` is one-hot at `Y` when `V & R`, else 0.
  - If `rise[i]` occurs with `pend[i]=1` and the line is not served this cycle, `pend[i]` stays 1 and `ovf` sets.
  - If `rise[i]` coincides with serving i, `pend[i]` stays 1 and `ovf` does not set.
- **`ovf` clear.** `clr` clears `ovf`. If set and `clr` occur in the same cycle, set wins.
- **FSM states: IDLE and PRESENT.**
  - IDLE: `V=0`. If `pend != 0`, register `Y = pick(pend)`, set `V=1`, go to PRESENT.
  - PRESENT: `V=1`; `Y` is held stable while `R=0`. On `V & R`: clear `pend[Y]`, update the pointer, drop `V`, go to IDLE.
- **Selection, RR=0:** highest set index of `pend`.
- **Selection, RR=1:** search `ptr+1, ptr+2, …` modulo 8; the first set bit wins. `ptr <= Y` on each handshake.
- **Selection freeze.** A newly pending higher-priority request never replaces a `Y` already being presented.
- **Reset values:** `pend=0`, `d_q=0`, `Y=0`, `V=0`, `ovf=0`, `ptr=7`, state IDLE.
  - Reset asserted during PRESENT discards the presented request.
  - `D` held high through reset release produces a rise on the first clock edge after release.

## Timing
- **Latency:** edge on `D[i]` sampled at clock edge t0 → `pend[i]=1` after t0 → `V=1`, `Y=i` after t1. Two cycles minimum.
- **Handshake:** the transfer completes at the edge where `V=R=1`. `V` is low the following cycle.
- **Throughput:** at most one grant every 2 cycles.
- **Outputs:** all registered; no combinational path from `D`/`R` to `Y`/`V`.
- **`pend` observation:** `pend` is visible the cycle after capture.
- **`R` while idle:** `R` asserted while `V=0` has no effect.

## Structure
- **Shared package `encoder_pkg`:**
  - `N_REQ=8`, `IDX_W=3`.
  - State enum `{IDLE, PRESENT}`.
  - `PTR_RESET=3'd7`.
- **Sub-module `prio_pick8`** (combinational):
  - Inputs: `pend[7:0]`, `start[2:0]`, `rr`.
  - Outputs: `idx[2:0]`, `any`.
  - Instantiated once; the FSM registers its output.

## Test plan
- **Fixed-priority grant order:** RR=0, `E=1`, pulse `D=8'h24`, hold `R=1`. Expect `V` high two cycles after the edge with `Y=5`, then `Y=2`, then `pend=0`, `V=0`.
- **Round-robin grant order:** RR=1, after reset set `pend=8'h81` via `D`, `R=1`. Expect grants `Y=0`, `Y=7`. Re-raise both and expect `Y=0` again (`ptr=7`).
- **Backpressure:** `R=0` for 5 cycles with `Y=3` presented, raise `D[6]` meanwhile. `Y` stays 3 and `V` stays 1. After `R=1`, the next grant is `Y=6`.
- **Overflow and clear:** second rise on `D[1]` while `pend[1]=1` → `ovf=1`. Rise coinciding with serve of index 1 → `pend[1]` stays 1, `ovf` unchanged. `clr` with a simultaneous new overflow → `ovf` stays 1.
- **Capture enable:** `E=0` with `D` toggling `8'hFF/00` → `pend` stays 0. `E=1` with `D` held high → no new capture until `D` falls and rises again.
- **Reset mid-transfer:** assert `rst_n=0` asynchronously in PRESENT. Expect `V=0`, `Y=0`, `pend=0`, `ovf=0` immediately, before the next clock edge.
